sram_multiport_ctrl: RTL and testbench

// Parametrised arbiter/controller for the external asynchronous 512 KB SRAM (19-bit address, 8-bit data,
// we_n only). It serves NPORTS requesters (CPU, video, DMA, ...) with round-robin or fixed priority and

---
 rtl/sram_multiport_ctrl.sv | 161 ++++++++++++++++
 tb/tb_sram_multiport_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_multiport_ctrl.sv
// Multi-port arbiter and timing controller for an external asynchronous SRAM
// with a single active-low write strobe. Requests are arbitrated round-robin or
// by fixed priority. Every SRAM-facing signal comes straight from a flop, so the
// pins never glitch. Each access walks SETUP -> ACCESS (WAIT+1) -> DONE.
module sram_multiport_ctrl #(
    parameter int AW     = 19,
    parameter int DW     = 8,
    parameter int NPORTS = 2,
    parameter int WAIT   = 2,
    parameter int RR     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPORTS-1:0]    req,
    input  logic [NPORTS-1:0]    we,
    input  logic [NPORTS*AW-1:0] addr,
    input  logic [NPORTS*DW-1:0] wdata,
    output logic [NPORTS-1:0]    ack,
    output logic [DW-1:0]        rdata,
    output logic [AW-1:0]        sram_addr,
    inout  wire  [DW-1:0]        sram_data,
    output logic                 sram_we_n
);

    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int CW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
    localparam logic [PW-1:0] LAST = PW'(NPORTS - 1);
    localparam logic [PW:0]   NP   = (PW + 1)'(NPORTS);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       gnt_q, gnt_d;
    logic                lwe_q, lwe_d;
    logic [AW-1:0]       laddr_q, laddr_d;
    logic [DW-1:0]       lwdata_q, lwdata_d;
    logic [NPORTS-1:0]   ack_q, ack_d;
    logic [DW-1:0]       rdata_q, rdata_d;
    logic                we_n_q, we_n_d;
    logic                oe_q, oe_d;
    logic [AW-1:0]       saddr_q, saddr_d;

    logic                arb_valid;
    logic [PW-1:0]       arb_idx;
    logic [PW-1:0]       ptr_eff;
    logic [2*NPORTS-1:0] rot;
    logic [PW:0]         sum;

    // Arbiter: rotate requests so the search starts at the pointer; lowest rotated index wins.
    always_comb begin
        arb_valid = 1'b0;
        arb_idx   = '0;
        sum       = '0;
        ptr_eff   = (RR != 0) ? ptr_q : '0;
        rot       = {req, req} >> ptr_eff;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                arb_valid = 1'b1;
                sum       = {1'b0, ptr_eff} + (PW + 1)'(i);
                arb_idx   = (sum >= NP) ? PW'(sum - NP) : PW'(sum);
            end
        end
    end

    // Next-state logic; pin values are computed from the next state so they leave a flop.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        lwe_d    = lwe_q;
        laddr_d  = laddr_q;
        lwdata_d = lwdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (arb_valid) begin
                    state_d = S_SETUP;
                    gnt_d   = arb_idx;
                    for (int p = 0; p < NPORTS; p++) begin
                        if (arb_idx == PW'(p)) begin
                            lwe_d    = we[p];
                            laddr_d  = addr[p*AW +: AW];
                            lwdata_d = wdata[p*DW +: DW];
                        end
                    end
                    if (RR != 0) begin
                        ptr_d = (arb_idx == LAST) ? '0 : arb_idx + 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = CW'(WAIT);
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    if (!lwe_q) begin
                        rdata_d = sram_data;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        we_n_d  = !((state_d == S_ACCESS) && lwe_d);
        oe_d    = lwe_d && (state_d != S_IDLE);
        saddr_d = (state_d == S_SETUP) ? laddr_d : saddr_q;
        ack_d   = '0;
        for (int p = 0; p < NPORTS; p++) begin
            ack_d[p] = (state_d == S_DONE) && (gnt_d == PW'(p));
        end
    end

    // Control and pin registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            lwe_q   <= 1'b0;
            ack_q   <= '0;
            rdata_q <= '0;
            we_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            saddr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            lwe_q   <= lwe_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            we_n_q  <= we_n_d;
            oe_q    <= oe_d;
            saddr_q <= saddr_d;
        end
    end

    // Latched request address/data; only meaningful while an access is granted.
    always_ff @(posedge clk) begin
        laddr_q  <= laddr_d;
        lwdata_q <= lwdata_d;
    end

    assign sram_data = oe_q ? lwdata_q : {DW{1'bz}};
    assign sram_addr = saddr_q;
    assign sram_we_n = we_n_q;
    assign ack       = ack_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_sram_multiport_ctrl.sv
// Testbench for sram_multiport_ctrl: three builds (RR/WAIT=2, fixed priority,
// WAIT=0), each attached to a simple SRAM model. Table vectors drive the main
// build; a scoreboard queue holds the expected ack port and read data.
`timescale 1ns/100ps
module tb_sram_multiport_ctrl;

    typedef struct { int port; logic we; logic [18:0] addr; logic [7:0] data; } vec_t;
    typedef struct { logic [1:0] ack; logic we; logic [7:0] rd; } exp_t;

    logic clk = 1'b0;
    always #18 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // build A: NPORTS=2, WAIT=2, RR=1
    logic rst_a;
    logic [1:0] req_a, we_a, ack_a;
    logic [37:0] addr_a;
    logic [15:0] wdata_a;
    logic [7:0] rdata_a;
    logic [18:0] sram_addr_a;
    logic sram_we_n_a;
    wire [7:0] bus_a;
    logic rd_mode_a;

    // build B: fixed priority
    logic rst_bc;
    logic [1:0] req_b, we_b, ack_b;
    logic [37:0] addr_b;
    logic [15:0] wdata_b;
    logic [7:0] rdata_b;
    logic [18:0] sram_addr_b;
    logic sram_we_n_b;
    wire [7:0] bus_b;

    // build C: WAIT=0
    logic [1:0] req_c, we_c, ack_c;
    logic [37:0] addr_c;
    logic [15:0] wdata_c;
    logic [7:0] rdata_c;
    logic [18:0] sram_addr_c;
    logic sram_we_n_c;
    wire [7:0] bus_c;
    logic rd_mode_c;

    sram_multiport_ctrl #(.AW(19), .DW(8), .NPORTS(2), .WAIT(2), .RR(1)) dut_a (
        .clk(clk), .rst(rst_a), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
        .ack(ack_a), .rdata(rdata_a), .sram_addr(sram_addr_a), .sram_data(bus_a),
        .sram_we_n(sram_we_n_a));

    sram_multiport_ctrl #(.AW(19), .DW(8), .NPORTS(2), .WAIT(2), .RR(0)) dut_b (
        .clk(clk), .rst(rst_bc), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
        .ack(ack_b), .rdata(rdata_b), .sram_addr(sram_addr_b), .sram_data(bus_b),
        .sram_we_n(sram_we_n_b));

    sram_multiport_ctrl #(.AW(19), .DW(8), .NPORTS(2), .WAIT(0), .RR(1)) dut_c (
        .clk(clk), .rst(rst_bc), .req(req_c), .we(we_c), .addr(addr_c), .wdata(wdata_c),
        .ack(ack_c), .rdata(rdata_c), .sram_addr(sram_addr_c), .sram_data(bus_c),
        .sram_we_n(sram_we_n_c));

    // SRAM models: drive the bus only in read phases, store while we_n is low
    logic [7:0] mem_a [0:524287];
    logic [7:0] mem_c;
    assign bus_a = (rd_mode_a && sram_we_n_a) ? mem_a[sram_addr_a] : 8'hzz;
    assign bus_c = (rd_mode_c && sram_we_n_c) ? mem_c : 8'hzz;
    always @(posedge clk) if (!sram_we_n_a) mem_a[sram_addr_a] <= bus_a;
    always @(posedge clk) if (!sram_we_n_c && sram_addr_c == 19'h7FFFF) mem_c <= bus_c;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int port, input logic w, input logic [7:0] rd);
        exp_t e;
        e.ack = 2'(1 << port);
        e.we  = w;
        e.rd  = rd;
        sb.push_back(e);
    endtask

    // Scoreboard and strobe monitor for build A
    int run_len = 0;
    logic [18:0] run_addr;
    exp_t ent;
    always @(negedge clk) begin
        if (rst_a) begin
            run_len = 0;
        end else begin
            if (ack_a != 2'b00) begin
                check("ack_onehot", 32'($countones(ack_a)), 32'd1);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: ack %b with nothing outstanding", ack_a);
                end else begin
                    ent = sb.pop_front();
                    check("ack_port", 32'(ack_a), 32'(ent.ack));
                    if (!ent.we) check("rdata", 32'(rdata_a), 32'(ent.rd));
                end
            end
            if (!sram_we_n_a) begin
                if (run_len == 0) run_addr = sram_addr_a;
                else check("addr_stable_we_low", 32'(sram_addr_a), 32'(run_addr));
                run_len++;
            end else if (run_len > 0) begin
                check("we_n_low_len", run_len, 3);
                run_len = 0;
            end
        end
    end

    task automatic wait_ack(input int d, output logic [1:0] got, output int n, output int wlow);
        logic [1:0] a;
        logic wn;
        got = 2'b00;
        n = 0;
        wlow = 0;
        while (got == 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
            case (d)
                0: begin a = ack_a; wn = sram_we_n_a; end
                1: begin a = ack_b; wn = sram_we_n_b; end
                default: begin a = ack_c; wn = sram_we_n_c; end
            endcase
            if (!wn) wlow++;
            got = a;
        end
        checks++;
        if (got == 2'b00) begin
            errors++;
            $display("FAIL ack_timeout dut%0d: no ack within %0d cycles, required an ack", d, n);
        end
    endtask

    logic [7:0] last_rd = 8'h00;

    task automatic run_vec(input vec_t v);
        logic [1:0] got;
        int n, wl;
        @(posedge clk); #1;
        rd_mode_a = !v.we;
        we_a[v.port] = v.we;
        addr_a[v.port*19 +: 19] = v.addr;
        wdata_a[v.port*8 +: 8] = v.data;
        req_a[v.port] = 1'b1;
        push_exp(v.port, v.we, v.data);
        wait_ack(0, got, n, wl);
        req_a = 2'b00;
        check("vec_latency", n, 6);
        check("vec_we_low_cycles", wl, v.we ? 3 : 0);
        if (v.we) begin
            check("ram_content", 32'(mem_a[v.addr]), 32'(v.data));
            check("rdata_hold", 32'(rdata_a), 32'(last_rd));
        end else begin
            last_rd = v.data;
        end
    endtask

    vec_t tbl [6];
    logic [1:0] got;
    int n, wl, t0;

    initial begin
        tbl[0] = '{0, 1'b1, 19'h12345, 8'hA5};
        tbl[1] = '{1, 1'b0, 19'h12345, 8'hA5};
        tbl[2] = '{0, 1'b1, 19'h00000, 8'h5A};
        tbl[3] = '{1, 1'b1, 19'h7FFFF, 8'hC3};
        tbl[4] = '{0, 1'b0, 19'h7FFFF, 8'hC3};
        tbl[5] = '{1, 1'b0, 19'h00000, 8'h5A};

        rst_a = 1'b1; rst_bc = 1'b1;
        req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0; rd_mode_a = 0;
        req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
        req_c = 0; we_c = 0; addr_c = 0; wdata_c = 0; rd_mode_c = 0; mem_c = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(ack_a), 32'd0);
        check("rst_rdata", 32'(rdata_a), 32'd0);
        check("rst_we_n", 32'(sram_we_n_a), 32'd1);
        check("rst_sram_addr", 32'(sram_addr_a), 32'd0);
        @(posedge clk); #1;
        rst_a = 1'b0; rst_bc = 1'b0;

        // single write/read vectors
        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // both ports held: alternate grants, back-to-back
        @(posedge clk); #1;
        rd_mode_a = 1'b0; we_a = 2'b11;
        addr_a = {19'h00200, 19'h00100}; wdata_a = {8'h22, 8'h11};
        req_a = 2'b11;
        for (int k = 0; k < 4; k++) push_exp(k % 2, 1'b1, 8'h00);
        for (int k = 0; k < 4; k++) begin
            wait_ack(0, got, n, wl);
            check("rr_grant", 32'(got), 32'(1 << (k % 2)));
            if (k > 0) check("rr_spacing", cyc - t0, 5);
            t0 = cyc;
            if (k == 0) begin addr_a[18:0] = 19'h00300; wdata_a[7:0] = 8'h33; end
            if (k == 1) begin addr_a[37:19] = 19'h00400; wdata_a[15:8] = 8'h44; end
            if (k == 3) req_a = 2'b00;
        end
        check("rr_ram_100", 32'(mem_a[19'h00100]), 32'h11);
        check("rr_ram_200", 32'(mem_a[19'h00200]), 32'h22);
        check("rr_ram_300", 32'(mem_a[19'h00300]), 32'h33);
        check("rr_ram_400", 32'(mem_a[19'h00400]), 32'h44);

        // reset during the 2nd ACCESS cycle of a write
        @(posedge clk); #1;
        we_a = 2'b01; addr_a[18:0] = 19'h00600; wdata_a[7:0] = 8'h77; req_a = 2'b01;
        repeat (3) @(posedge clk);
        #1; rst_a = 1'b1; req_a = 2'b00;
        @(posedge clk); #1; rst_a = 1'b0;
        @(negedge clk);
        check("abort_we_n", 32'(sram_we_n_a), 32'd1);
        check("abort_ack", 32'(ack_a), 32'd0);
        check("abort_sram_addr", 32'(sram_addr_a), 32'd0);
        check("abort_rdata", 32'(rdata_a), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("abort_no_ack", 32'(ack_a), 32'd0);
        end
        @(posedge clk); #1;
        we_a = 2'b11; addr_a = {19'h00800, 19'h00700}; wdata_a = {8'h66, 8'h55};
        req_a = 2'b11;
        push_exp(0, 1'b1, 8'h00);
        push_exp(1, 1'b1, 8'h00);
        wait_ack(0, got, n, wl);
        check("post_rst_grant0", 32'(got), 32'b01);
        check("post_rst_latency", n, 6);
        t0 = cyc;
        wait_ack(0, got, n, wl);
        req_a = 2'b00;
        check("post_rst_grant1", 32'(got), 32'b10);
        check("post_rst_spacing", cyc - t0, 5);
        check("post_rst_ram", 32'(mem_a[19'h00700]), 32'h55);

        // fixed priority build
        @(posedge clk); #1;
        we_b = 2'b11; addr_b = {19'h00020, 19'h00010}; wdata_b = 16'h2010;
        req_b = 2'b11;
        for (int k = 0; k < 3; k++) begin
            wait_ack(1, got, n, wl);
            check("fp_only_port0", 32'(got), 32'b01);
            if (k == 2) req_b[0] = 1'b0;
            t0 = cyc;
        end
        wait_ack(1, got, n, wl);
        req_b = 2'b00;
        check("fp_port1_after_drop", 32'(got), 32'b10);
        check("fp_spacing", cyc - t0, 5);

        // WAIT=0 build
        @(posedge clk); #1;
        we_c = 2'b01; addr_c[18:0] = 19'h7FFFF; wdata_c[7:0] = 8'h3C; req_c = 2'b01;
        wait_ack(2, got, n, wl);
        req_c = 2'b00;
        check("w0_wr_ack", 32'(got), 32'b01);
        check("w0_wr_latency", n, 4);
        check("w0_we_low", wl, 1);
        check("w0_ram", 32'(mem_c), 32'h3C);
        @(posedge clk); #1;
        rd_mode_c = 1'b1; we_c = 2'b00; addr_c[37:19] = 19'h7FFFF; req_c = 2'b10;
        wait_ack(2, got, n, wl);
        req_c = 2'b00;
        check("w0_rd_ack", 32'(got), 32'b10);
        check("w0_rd_latency", n, 4);
        check("w0_rd_we_low", wl, 0);
        check("w0_rdata", 32'(rdata_c), 32'h3C);
        @(posedge clk); #1;
        addr_c = {19'h7FFFF, 19'h7FFFF}; req_c = 2'b11;
        wait_ack(2, got, n, wl);
        check("w0_b2b_first", 32'(got), 32'b01);
        t0 = cyc;
        wait_ack(2, got, n, wl);
        req_c = 2'b00;
        check("w0_b2b_second", 32'(got), 32'b10);
        check("w0_occupancy", cyc - t0, 3);
        check("w0_b2b_rdata", 32'(rdata_c), 32'h3C);

        repeat (3) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
